addpath_sequencer: RTL and testbench

Controller that runs the add-path program stored in the 64-bit single-port RAM. It fetches instruction words and reads two operand words. It computes a 64-bit ADD or SUB and writes the result back to the same RAM. Sits between the top level (start/done) and the RAM, and is the only master driving the RAM address, enables and write data.

---
 rtl/addpath_pkg.sv | 31 +++
 rtl/addpath_alu.sv | 21 ++
 rtl/addpath_sequencer.sv | 149 ++++++++++++++
 tb/tb_addpath_sequencer.sv | 349 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/addpath_pkg.sv
// Shared types and instruction-field layout for the add-path sequencer.
package addpath_pkg;

  typedef enum logic [2:0] {
    StIdle,
    StFetch,
    StRda,
    StRdb,
    StWb,
    StDone
  } state_e;

  localparam logic [5:0] OP_ADD  = 6'd0;
  localparam logic [5:0] OP_SUB  = 6'd1;
  localparam logic [5:0] OP_HALT = 6'd63;

  // Instruction word layout; bits above DST are ignored.
  localparam int unsigned OPC_LSB  = 0;
  localparam int unsigned OPC_W    = 6;
  localparam int unsigned SRCA_LSB = 6;
  localparam int unsigned SRCA_W   = 6;
  localparam int unsigned SRCB_LSB = 12;
  localparam int unsigned SRCB_W   = 6;
  localparam int unsigned DST_LSB  = 18;
  localparam int unsigned DST_W    = 7;

  function automatic logic is_arith(input logic [5:0] op);
    return (op == OP_ADD) || (op == OP_SUB);
  endfunction

endpackage

// File: rtl/addpath_alu.sv
// Combinational modulo-2^DATA_W adder/subtractor selected by opcode.
module addpath_alu
  import addpath_pkg::*;
#(
  parameter int unsigned DATA_W = 64
) (
  input  logic [DATA_W-1:0] i_a,
  input  logic [DATA_W-1:0] i_b,
  input  logic [5:0]        i_op,
  output logic [DATA_W-1:0] o_y
);

  // SUB gives A-B, everything else is treated as ADD.
  always_comb begin
    o_y = i_a + i_b;
    if (i_op == OP_SUB) begin
      o_y = i_a - i_b;
    end
  end

endmodule

// File: rtl/addpath_sequencer.sv
// Runs the add-path program held in a single-port RAM: fetch, read two
// operands, write ADD/SUB result back. Sole master of the RAM port.
module addpath_sequencer
  import addpath_pkg::*;
#(
  parameter int unsigned      ADR_W    = 16,
  parameter int unsigned      DATA_W   = 64,
  parameter logic [ADR_W-1:0] START_PC = '0
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_start,
  output logic              o_busy,
  output logic              o_done,
  output logic [ADR_W-1:0]  o_pc,
  output logic [15:0]       o_retired,
  output logic [ADR_W-1:0]  o_ram_adr,
  output logic [DATA_W-1:0] o_ram_writeData,
  output logic              o_ram_readEn,
  output logic              o_ram_writeEn,
  input  logic [DATA_W-1:0] i_ram_readData
);

  state_e              r_state;
  logic [ADR_W-1:0]    r_pc;
  logic [15:0]         r_retired;
  logic [5:0]          r_op;
  logic [ADR_W-1:0]    r_srcb;
  logic [ADR_W-1:0]    r_dst;
  logic [DATA_W-1:0]   r_opa;
  logic [ADR_W-1:0]    r_adr;
  logic [DATA_W-1:0]   r_wdata;
  logic                r_rd_en;
  logic                r_wr_en;
  logic                r_busy;
  logic                r_done;

  logic [5:0]          w_op;
  logic [ADR_W-1:0]    w_srca;
  logic [ADR_W-1:0]    w_srcb;
  logic [ADR_W-1:0]    w_dst;
  logic [ADR_W-1:0]    w_pc_inc;
  logic [DATA_W-1:0]   w_alu_y;

  // Instruction fields decoded straight off the read bus during FETCH.
  assign w_op     = i_ram_readData[OPC_LSB +: OPC_W];
  assign w_srca   = ADR_W'(i_ram_readData[SRCA_LSB +: SRCA_W]);
  assign w_srcb   = ADR_W'(i_ram_readData[SRCB_LSB +: SRCB_W]);
  assign w_dst    = ADR_W'(i_ram_readData[DST_LSB +: DST_W]);
  assign w_pc_inc = r_pc + 1'b1;

  // Operand B is consumed from the read bus in RDB; the result is registered.
  addpath_alu #(
    .DATA_W (DATA_W)
  ) u_alu (
    .i_a  (r_opa),
    .i_b  (i_ram_readData),
    .i_op (r_op),
    .o_y  (w_alu_y)
  );

  // Sequencer FSM; every RAM-facing output is registered for the next state.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_state   <= StIdle;
      r_pc      <= START_PC;
      r_retired <= '0;
      r_op      <= '0;
      r_srcb    <= '0;
      r_dst     <= '0;
      r_opa     <= '0;
      r_adr     <= '0;
      r_wdata   <= '0;
      r_rd_en   <= 1'b0;
      r_wr_en   <= 1'b0;
      r_busy    <= 1'b0;
      r_done    <= 1'b0;
    end else begin
      unique case (r_state)
        StIdle: begin
          if (i_start) begin
            r_pc      <= START_PC;
            r_retired <= '0;
            r_adr     <= START_PC;
            r_rd_en   <= 1'b1;
            r_busy    <= 1'b1;
            r_state   <= StFetch;
          end
        end
        StFetch: begin
          r_op   <= w_op;
          r_srcb <= w_srcb;
          r_dst  <= w_dst;
          if (w_op == OP_HALT) begin
            // pc keeps the HALT address through DONE and IDLE.
            r_rd_en <= 1'b0;
            r_done  <= 1'b1;
            r_state <= StDone;
          end else if (is_arith(w_op)) begin
            r_adr   <= w_srca;
            r_state <= StRda;
          end else begin
            r_pc  <= w_pc_inc;
            r_adr <= w_pc_inc;
          end
        end
        StRda: begin
          r_opa   <= i_ram_readData;
          r_adr   <= r_srcb;
          r_state <= StRdb;
        end
        StRdb: begin
          r_wdata <= w_alu_y;
          r_adr   <= r_dst;
          r_rd_en <= 1'b0;
          r_wr_en <= 1'b1;
          r_state <= StWb;
        end
        StWb: begin
          r_wdata   <= '0;
          r_wr_en   <= 1'b0;
          r_rd_en   <= 1'b1;
          r_retired <= r_retired + 16'd1;
          r_pc      <= w_pc_inc;
          r_adr     <= w_pc_inc;
          r_state   <= StFetch;
        end
        StDone: begin
          r_done  <= 1'b0;
          r_busy  <= 1'b0;
          r_state <= StIdle;
        end
        default: begin
          r_state <= StIdle;
        end
      endcase
    end
  end

  assign o_busy          = r_busy;
  assign o_done          = r_done;
  assign o_pc            = r_pc;
  assign o_retired       = r_retired;
  assign o_ram_adr       = r_adr;
  assign o_ram_writeData = r_wdata;
  assign o_ram_readEn    = r_rd_en;
  assign o_ram_writeEn   = r_wr_en;

endmodule

// File: tb/tb_addpath_sequencer.sv
// Bench for addpath_sequencer: an instruction-level interpreter predicts the
// RAM bus cycle by cycle; directed programs plus literal result checks.
module tb_addpath_sequencer;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic        start2;

  logic        busy, done, rd_en, wr_en;
  logic [15:0] pc, retired, adr;
  logic [63:0] wdata, rdata;

  logic        busy2, done2, rd_en2, wr_en2;
  logic [15:0] pc2, retired2, adr2;
  logic [63:0] wdata2, rdata2;

  logic [63:0] mem [0:127];
  logic [63:0] mm  [0:127];

  typedef struct packed {
    logic        busy;
    logic        done;
    logic        rd;
    logic        wr;
    logic        adr_chk;
    logic [15:0] adr;
    logic [63:0] wd;
    logic [15:0] pc;
    logic [15:0] ret;
  } rec_t;

  rec_t        q[$];
  logic        chk_en = 1'b0;
  int          cyc = 0;
  int          done_cnt = 0;
  int          done_cyc = 0;
  logic [15:0] adr_at [0:15];
  int          n_err = 0;
  int          n_chk = 0;

  always #5 clk = ~clk;

  addpath_sequencer #(
    .ADR_W    (16),
    .DATA_W   (64),
    .START_PC (16'h0000)
  ) dut (
    .i_clk           (clk),
    .i_rst           (rst),
    .i_start         (start),
    .o_busy          (busy),
    .o_done          (done),
    .o_pc            (pc),
    .o_retired       (retired),
    .o_ram_adr       (adr),
    .o_ram_writeData (wdata),
    .o_ram_readEn    (rd_en),
    .o_ram_writeEn   (wr_en),
    .i_ram_readData  (rdata)
  );

  addpath_sequencer #(
    .ADR_W    (16),
    .DATA_W   (64),
    .START_PC (16'hFFFF)
  ) dut2 (
    .i_clk           (clk),
    .i_rst           (rst),
    .i_start         (start2),
    .o_busy          (busy2),
    .o_done          (done2),
    .o_pc            (pc2),
    .o_retired       (retired2),
    .o_ram_adr       (adr2),
    .o_ram_writeData (wdata2),
    .o_ram_readEn    (rd_en2),
    .o_ram_writeEn   (wr_en2),
    .i_ram_readData  (rdata2)
  );

  // RAM model: combinational read, write at the rising edge.
  assign rdata  = (adr < 16'd128) ? mem[adr[6:0]] : 64'd0;
  assign rdata2 = (adr2 == 16'hFFFF) ? 64'd5 : (adr2 == 16'h0000) ? 64'd63 : 64'd0;

  always @(posedge clk) begin
    if (wr_en && adr < 16'd128) mem[adr[6:0]] = wdata;
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [63:0] enc(input logic [5:0] op, input logic [5:0] sa,
                                      input logic [5:0] sb, input logic [6:0] d);
    return {39'd0, d, sb, sa, op};
  endfunction

  task automatic clear_mem();
    for (int i = 0; i < 128; i++) begin
      mem[i] = 64'd0;
      mm[i]  = 64'd0;
    end
  endtask

  task automatic put(input int a, input logic [63:0] v);
    mem[a] = v;
    mm[a]  = v;
  endtask

  function automatic logic [63:0] mrd(input logic [15:0] a);
    return (a < 16'd128) ? mm[a[6:0]] : 64'd0;
  endfunction

  task automatic push(input logic b, input logic dn, input logic rd, input logic wr,
                      input logic ac, input logic [15:0] a, input logic [63:0] wd,
                      input logic [15:0] p, input logic [15:0] r);
    rec_t e;
    e = '{busy: b, done: dn, rd: rd, wr: wr, adr_chk: ac, adr: a, wd: wd, pc: p, ret: r};
    q.push_back(e);
  endtask

  // Interprets the program on the model memory, emitting one record per cycle
  // from the first FETCH through the IDLE cycle after DONE.
  task automatic model_run(input logic [15:0] spc);
    logic [15:0] p, r, sa, sb, d;
    logic [63:0] ins, a, b, res;
    logic [5:0]  op;
    p = spc;
    r = 16'd0;
    for (int n = 0; n < 64; n++) begin
      ins = mrd(p);
      op  = ins[5:0];
      push(1, 0, 1, 0, 1, p, 64'd0, p, r);
      if (op == 6'd63) begin
        push(1, 1, 0, 0, 0, 16'd0, 64'd0, p, r);
        push(0, 0, 0, 0, 0, 16'd0, 64'd0, p, r);
        return;
      end
      if (op == 6'd0 || op == 6'd1) begin
        sa  = {10'd0, ins[11:6]};
        sb  = {10'd0, ins[17:12]};
        d   = {9'd0, ins[24:18]};
        a   = mrd(sa);
        push(1, 0, 1, 0, 1, sa, 64'd0, p, r);
        b   = mrd(sb);
        push(1, 0, 1, 0, 1, sb, 64'd0, p, r);
        res = (op == 6'd1) ? a - b : a + b;
        push(1, 0, 0, 1, 1, d, res, p, r);
        if (d < 16'd128) mm[d[6:0]] = res;
        r = r + 16'd1;
      end
      p = p + 16'd1;
    end
  endtask

  // Single compare process: checks every enabled cycle against the model.
  always @(negedge clk) begin
    rec_t e;
    if (chk_en) begin
      cyc++;
      if (cyc < 16) adr_at[cyc] = adr;
      if (done) begin
        done_cnt++;
        done_cyc = cyc;
      end
      if (q.size() != 0) begin
        e = q.pop_front();
        chk("busy", {63'd0, busy}, {63'd0, e.busy});
        chk("done", {63'd0, done}, {63'd0, e.done});
        chk("ram_readEn", {63'd0, rd_en}, {63'd0, e.rd});
        chk("ram_writeEn", {63'd0, wr_en}, {63'd0, e.wr});
        if (e.adr_chk) chk("ram_adr", {48'd0, adr}, {48'd0, e.adr});
        chk("ram_writeData", wdata, e.wd);
        chk("pc", {48'd0, pc}, {48'd0, e.pc});
        chk("retired", {48'd0, retired}, {48'd0, e.ret});
      end
    end
  end

  // Start pulse sampled at edge 0; start is held for 'hold' further edges.
  task automatic launch(input int hold);
    @(negedge clk);
    start = 1'b1;
    @(posedge clk);
    #1;
    cyc      = 0;
    done_cnt = 0;
    done_cyc = 0;
    chk_en   = 1'b1;
    if (hold > 0) begin
      repeat (hold) @(posedge clk);
      #1;
    end
    start = 1'b0;
  endtask

  task automatic drain(input int budget);
    for (int i = 0; i < budget && q.size() != 0; i++) @(posedge clk);
    #1;
    chk("drain", {63'd0, q.size() == 0}, 64'd1);
    chk_en = 1'b0;
    q.delete();
  endtask

  initial begin
    int l1;
    rst    = 1'b1;
    start  = 1'b0;
    start2 = 1'b0;
    clear_mem();
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;

    // Reset state
    chk("rst_busy", {63'd0, busy}, 64'd0);
    chk("rst_done", {63'd0, done}, 64'd0);
    chk("rst_rd", {63'd0, rd_en}, 64'd0);
    chk("rst_wr", {63'd0, wr_en}, 64'd0);
    chk("rst_pc", {48'd0, pc}, 64'd0);
    chk("rst_retired", {48'd0, retired}, 64'd0);
    chk("rst_adr", {48'd0, adr}, 64'd0);
    chk("rst_wdata", wdata, 64'd0);
    chk("rst_pc2", {48'd0, pc2}, 64'hFFFF);

    // Basic ADD
    clear_mem();
    put(0, enc(6'd0, 6'd10, 6'd11, 7'd12));
    put(1, 64'd63);
    put(10, 64'd5);
    put(11, 64'd7);
    model_run(16'd0);
    launch(0);
    drain(50);
    chk("add_result", mem[12], 64'd12);
    chk("add_done_cnt", 64'(done_cnt), 64'd1);
    chk("add_done_cyc", 64'(done_cyc), 64'd6);
    chk("add_retired", {48'd0, retired}, 64'd1);
    chk("add_pc", {48'd0, pc}, 64'd1);

    // SUB wrap
    clear_mem();
    put(0, enc(6'd1, 6'd10, 6'd11, 7'd12));
    put(1, 64'd63);
    put(10, 64'd0);
    put(11, 64'd1);
    model_run(16'd0);
    launch(0);
    drain(50);
    chk("sub_wrap", mem[12], 64'hFFFF_FFFF_FFFF_FFFF);

    // NOP and in-place operands
    clear_mem();
    put(0, 64'd5);
    put(1, enc(6'd0, 6'd3, 6'd3, 7'd3));
    put(2, 64'd63);
    put(3, 64'd9);
    model_run(16'd0);
    launch(0);
    drain(50);
    chk("nop_result", mem[3], 64'd18);
    chk("nop_retired", {48'd0, retired}, 64'd1);
    chk("nop_fetch1_adr", {48'd0, adr_at[2]}, 64'd1);

    // Self-modifying: instruction 0 turns word 1 into HALT
    clear_mem();
    put(0, enc(6'd0, 6'd20, 6'd21, 7'd1));
    put(1, 64'd5);
    put(2, 64'd63);
    put(20, 64'd63);
    put(21, 64'd0);
    model_run(16'd0);
    launch(0);
    drain(50);
    chk("smc_pc", {48'd0, pc}, 64'd1);
    chk("smc_done", 64'(done_cnt), 64'd1);
    chk("smc_word", mem[1], 64'd63);

    // Async reset in the middle of WB
    clear_mem();
    put(0, enc(6'd0, 6'd10, 6'd11, 7'd12));
    put(1, 64'd63);
    put(10, 64'd5);
    put(11, 64'd7);
    put(12, 64'hDEAD);
    @(negedge clk);
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("wb_we", {63'd0, wr_en}, 64'd1);
    #2;
    rst = 1'b1;
    #1;
    chk("arst_we", {63'd0, wr_en}, 64'd0);
    chk("arst_busy", {63'd0, busy}, 64'd0);
    chk("arst_pc", {48'd0, pc}, 64'd0);
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    chk("arst_mem", mem[12], 64'hDEAD);

    // start held high: ignored while busy, restarts after DONE
    clear_mem();
    put(0, enc(6'd0, 6'd10, 6'd12, 7'd12));
    put(1, 64'd63);
    put(10, 64'd5);
    put(12, 64'd1);
    model_run(16'd0);
    l1 = q.size();
    model_run(16'd0);
    launch(l1);
    drain(100);
    chk("rerun_result", mem[12], 64'd11);
    chk("rerun_done_cnt", 64'(done_cnt), 64'd2);

    // PC wrap on the START_PC=FFFF instance
    @(negedge clk);
    start2 = 1'b1;
    @(posedge clk);
    #1;
    start2 = 1'b0;
    @(negedge clk);
    chk("wrap_c1_pc", {48'd0, pc2}, 64'hFFFF);
    chk("wrap_c1_adr", {48'd0, adr2}, 64'hFFFF);
    chk("wrap_c1_rd", {63'd0, rd_en2}, 64'd1);
    @(negedge clk);
    chk("wrap_c2_pc", {48'd0, pc2}, 64'd0);
    chk("wrap_c2_adr", {48'd0, adr2}, 64'd0);
    @(negedge clk);
    chk("wrap_c3_done", {63'd0, done2}, 64'd1);
    chk("wrap_c3_pc", {48'd0, pc2}, 64'd0);
    chk("wrap_c3_ret", {48'd0, retired2}, 64'd0);
    @(negedge clk);
    chk("wrap_c4_busy", {63'd0, busy2}, 64'd0);
    chk("wrap_c4_done", {63'd0, done2}, 64'd0);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
